// File: rtl/ds_decim.sv
`default_nettype none
// ============================================================================
// Module   : ds_decim
// Brief    : Four-channel decimating accumulator. Sums 2^DS_LOG2 samples per
//            channel from a channel-tagged ADC stream and publishes all four
//            16-bit scaled sums together once every channel has completed a
//            block. Sticky overrun flag for a channel completing twice before
//            the frame commits.
// Revision : 1.0 - initial release
// ============================================================================
module ds_decim #(
    parameter int DS_LOG2 = 4,
    parameter int ADC_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [1:0]       adc_ch,
    input  logic             adc_valid,
    output logic [15:0]      ds_result0,
    output logic [15:0]      ds_result1,
    output logic [15:0]      ds_result2,
    output logic [15:0]      ds_result3,
    output logic             ds_valid,
    output logic             ds_ovf
);

    // Accumulator is wide enough that a full block of maximum samples
    // never overflows.
    localparam int ACC_W = ADC_W + DS_LOG2;

    localparam logic [DS_LOG2-1:0] c_cnt_last = '1;
    localparam logic [DS_LOG2-1:0] c_cnt_one  = DS_LOG2'(1);
    localparam logic [3:0]         c_all_done = 4'b1111;

    // Per-channel running state
    logic [ACC_W-1:0]   r_acc [4];
    logic [DS_LOG2-1:0] r_cnt [4];
    logic [15:0]        r_shd [4];
    logic [3:0]         r_done;

    // Committed frame
    logic [15:0]        r_res [4];
    logic               r_valid;
    logic               r_ovf;

    // Selected-channel arithmetic
    logic [ACC_W-1:0]   w_sum;
    logic [15:0]        w_scaled;
    logic               w_last;
    logic [3:0]         w_ch_onehot;
    logic [3:0]         w_done_next;
    logic               w_commit;

    // Sum of the tagged channel plus the incoming sample, and whether this
    // sample closes a block and with it the whole frame.
    always_comb begin
        w_sum       = r_acc[adc_ch] + ACC_W'(adc_data);
        // Upper 16 bits of the block sum; truncation, no rounding.
        w_scaled    = w_sum[ACC_W-1 -: 16];
        w_last      = adc_valid && (r_cnt[adc_ch] == c_cnt_last);
        w_ch_onehot = 4'b0001 << adc_ch;
        w_done_next = r_done | w_ch_onehot;
        w_commit    = w_last && (w_done_next == c_all_done);
    end

    // Per-channel accumulate / block completion; the next block starts on
    // the very next sample so nothing is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                r_acc[c] <= '0;
                r_cnt[c] <= '0;
                r_shd[c] <= '0;
            end
        end else if (adc_valid) begin
            if (w_last) begin
                r_acc[adc_ch] <= '0;
                r_cnt[adc_ch] <= '0;
                r_shd[adc_ch] <= w_scaled;
            end else begin
                r_acc[adc_ch] <= w_sum;
                r_cnt[adc_ch] <= r_cnt[adc_ch] + c_cnt_one;
            end
        end
    end

    // Frame tracking: done flags, overrun detection and coherent commit of
    // all four results (fresh value bypasses the shadow for the closing
    // channel).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                r_res[c] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            if (w_last) begin
                if (r_done[adc_ch]) begin
                    r_ovf <= 1'b1;
                end
                if (w_commit) begin
                    r_done  <= '0;
                    r_valid <= 1'b1;
                    for (int c = 0; c < 4; c++) begin
                        r_res[c] <= (2'(c) == adc_ch) ? w_scaled : r_shd[c];
                    end
                end else begin
                    r_done <= w_done_next;
                end
            end
        end
    end

    assign ds_result0 = r_res[0];
    assign ds_result1 = r_res[1];
    assign ds_result2 = r_res[2];
    assign ds_result3 = r_res[3];
    assign ds_valid   = r_valid;
    assign ds_ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ds_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_ds_decim
// Brief    : Self-checking bench for ds_decim. Two instances (DS_LOG2=4 and
//            DS_LOG2=5) are checked every cycle against a queue-based model
//            that sums each completed block of samples directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ds_decim;

    localparam int LG_A = 4;
    localparam int LG_B = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Instance A (DS_LOG2=4) and B (DS_LOG2=5) stimulus / observation
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0]  a_ch = '0,      b_ch = '0;
    logic [11:0] a_data = '0,    b_data = '0;
    logic [15:0] a_res [4];
    logic [15:0] b_res [4];
    logic        a_dv, b_dv, a_ovf, b_ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: raw samples of the block in progress, the
    // latest completed value per channel, and the last committed frame.
    int unsigned mq [8][$];
    logic [15:0] m_pend [2][4];
    logic [15:0] m_res  [2][4];
    bit          m_have [2][4];
    bit          m_valid [2];
    bit          m_ovf   [2];

    always #5 clk = ~clk;

    ds_decim #(.DS_LOG2(LG_A), .ADC_W(12)) u_dut_a (
        .clk(clk), .rst(rst),
        .adc_data(a_data), .adc_ch(a_ch), .adc_valid(a_valid),
        .ds_result0(a_res[0]), .ds_result1(a_res[1]),
        .ds_result2(a_res[2]), .ds_result3(a_res[3]),
        .ds_valid(a_dv), .ds_ovf(a_ovf)
    );

    ds_decim #(.DS_LOG2(LG_B), .ADC_W(12)) u_dut_b (
        .clk(clk), .rst(rst),
        .adc_data(b_data), .adc_ch(b_ch), .adc_valid(b_valid),
        .ds_result0(b_res[0]), .ds_result1(b_res[1]),
        .ds_result2(b_res[2]), .ds_result3(b_res[3]),
        .ds_valid(b_dv), .ds_ovf(b_ovf)
    );

    function automatic int lg(input int k);
        return (k == 0) ? LG_A : LG_B;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_ovf[k]   = 1'b0;
            for (int c = 0; c < 4; c++) begin
                mq[k*4+c].delete();
                m_pend[k][c] = '0;
                m_res[k][c]  = '0;
                m_have[k][c] = 1'b0;
            end
        end
    endtask

    task automatic model_accept(input int k, input bit v, input int c, input int d);
        int unsigned sum;
        int idx;
        m_valid[k] = 1'b0;
        if (v) begin
            idx = k*4 + c;
            mq[idx].push_back(d);
            if (mq[idx].size() == (1 << lg(k))) begin
                sum = 0;
                for (int i = 0; i < mq[idx].size(); i++) sum += mq[idx][i];
                mq[idx].delete();
                if (m_have[k][c]) m_ovf[k] = 1'b1;
                m_pend[k][c] = 16'(sum >> (lg(k) - 4));
                m_have[k][c] = 1'b1;
                if (m_have[k][0] && m_have[k][1] && m_have[k][2] && m_have[k][3]) begin
                    for (int j = 0; j < 4; j++) begin
                        m_res[k][j]  = m_pend[k][j];
                        m_have[k][j] = 1'b0;
                    end
                    m_valid[k] = 1'b1;
                end
            end
        end
    endtask

    // One clock: present inputs, let the edge happen, update the model,
    // then leave the bench 1 time unit after the edge for sampling.
    task automatic step(input bit va, input int ca, input int da,
                        input bit vb, input int cb, input int db);
        a_valid = va; a_ch = 2'(ca); a_data = 12'(da);
        b_valid = vb; b_ch = 2'(cb); b_data = 12'(db);
        @(posedge clk);
        model_accept(0, va, ca, da);
        model_accept(1, vb, cb, db);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            a_valid = i[0]; a_ch = 2'(i); a_data = 12'hFFF;
            b_valid = ~i[0]; b_ch = 2'(i); b_data = 12'hFFF;
            @(posedge clk);
            model_reset();
            #1;
        end
        rst = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_valid = ~i[0]; a_ch = 2'(i); a_data = 12'h7FF;
            b_valid = ~i[0]; b_ch = 2'(i); b_data = 12'h7FF;
            @(posedge clk);
            model_reset();
            #1;
            tests_run++;
            if ((a_dv !== 1'b0) || (b_dv !== 1'b0)) begin
                tests_failed++;
                $display("FAIL reset_valid cycle %0d got a=%b b=%b exp 0", i, a_dv, b_dv);
            end
        end
        rst = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if ((a_res[c] !== 16'h0000) || (b_res[c] !== 16'h0000)) begin
                tests_failed++;
                $display("FAIL reset_res%0d got a=%h b=%h exp 0000", c, a_res[c], b_res[c]);
            end
        end
        tests_run++;
        if ((a_ovf !== 1'b0) || (b_ovf !== 1'b0)) begin
            tests_failed++;
            $display("FAIL reset_ovf got a=%b b=%b exp 0", a_ovf, b_ovf);
        end
    endtask

    task automatic test_round_robin();
        int pulses = 0;
        int at     = -1;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, i % 4, 12'hABC, 1'b0, 0, 0);
            tests_run++;
            if (a_dv !== m_valid[0]) begin
                tests_failed++;
                $display("FAIL rr_valid sample %0d got %b exp %b", i, a_dv, m_valid[0]);
            end
            if (a_dv === 1'b1) begin pulses++; at = i; end
        end
        tests_run++;
        if ((pulses != 1) || (at != 63)) begin
            tests_failed++;
            $display("FAIL rr_pulse got %0d pulses at %0d exp 1 at 63", pulses, at);
        end
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (a_res[c] !== 16'hABC0) begin
                tests_failed++;
                $display("FAIL rr_res%0d got %h exp abc0", c, a_res[c]);
            end
        end
        tests_run++;
        if (a_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_ovf got %b exp 0", a_ovf);
        end
    endtask

    task automatic test_full_scale_l5();
        int pulses = 0;
        for (int i = 0; i < 128; i++) begin
            step(1'b0, 0, 0, 1'b1, i % 4, 12'hFFF);
            tests_run++;
            if (b_dv !== m_valid[1]) begin
                tests_failed++;
                $display("FAIL fs_valid sample %0d got %b exp %b", i, b_dv, m_valid[1]);
            end
            if (b_dv === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL fs_pulses got %0d exp 1", pulses);
        end
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (b_res[c] !== 16'hFFF0) begin
                tests_failed++;
                $display("FAIL fs_res%0d got %h exp fff0", c, b_res[c]);
            end
        end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        apply_reset(1);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 2, i % 16, 1'b0, 0, 0);
            if (a_dv === 1'b1) pulses++;
        end
        tests_run++;
        if ((pulses != 0) || (a_ovf !== 1'b1)) begin
            tests_failed++;
            $display("FAIL ovr_flag got pulses=%0d ovf=%b exp 0 and 1", pulses, a_ovf);
        end
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 16; i++) begin
                step(1'b1, (n == 2) ? 3 : n, 1, 1'b0, 0, 0);
                tests_run++;
                if (a_dv !== m_valid[0]) begin
                    tests_failed++;
                    $display("FAIL ovr_valid ch-group %0d sample %0d got %b exp %b", n, i, a_dv, m_valid[0]);
                end
                if (a_dv === 1'b1) pulses++;
            end
        end
        tests_run++;
        if ((pulses != 1) || (a_res[2] !== 16'h0078)) begin
            tests_failed++;
            $display("FAIL ovr_res2 got %h pulses=%0d exp 0078 pulses=1", a_res[2], pulses);
        end
        tests_run++;
        if ((a_res[0] !== 16'h0010) || (a_res[1] !== 16'h0010) || (a_res[3] !== 16'h0010)) begin
            tests_failed++;
            $display("FAIL ovr_res013 got %h %h %h exp 0010", a_res[0], a_res[1], a_res[3]);
        end
        tests_run++;
        if (a_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_sticky got %b exp 1", a_ovf);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 32; i++) step(1'b1, i % 4, 12'h100, 1'b1, i % 4, 12'h100);
        apply_reset(1);
        tests_run++;
        if ((a_res[0] !== 16'h0) || (a_ovf !== 1'b0) || (b_res[0] !== 16'h0)) begin
            tests_failed++;
            $display("FAIL mid_reset_clear got res=%h ovf=%b bres=%h exp 0", a_res[0], a_ovf, b_res[0]);
        end
        for (int i = 0; i < 64; i++) begin
            step(1'b1, i % 4, 12'h010, 1'b0, 0, 0);
            tests_run++;
            if (a_dv !== m_valid[0]) begin
                tests_failed++;
                $display("FAIL mid_valid sample %0d got %b exp %b", i, a_dv, m_valid[0]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (a_res[c] !== 16'h0100) begin
                tests_failed++;
                $display("FAIL mid_res%0d got %h exp 0100", c, a_res[c]);
            end
        end
    endtask

    task automatic test_uneven();
        int rem [3];
        int c;
        int left = 48;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 3, $urandom_range(0, 4095), 1'b0, 0, 0);
            tests_run++;
            if (a_dv !== 1'b0) begin
                tests_failed++;
                $display("FAIL un_early ch3 sample %0d got %b exp 0", i, a_dv);
            end
        end
        rem[0] = 16; rem[1] = 16; rem[2] = 16;
        while (left > 0) begin
            c = $urandom_range(0, 2);
            if (rem[c] == 0) continue;
            rem[c]--;
            left--;
            step(1'b1, c, $urandom_range(0, 4095), 1'b0, 0, 0);
            tests_run++;
            if (a_dv !== ((left == 0) ? 1'b1 : 1'b0)) begin
                tests_failed++;
                $display("FAIL un_valid left=%0d got %b exp %b", left, a_dv, (left == 0));
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, 0, 0, 1'b0, 0, 0);
        end
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (a_res[j] !== m_res[0][j]) begin
                tests_failed++;
                $display("FAIL un_res%0d got %h exp %h", j, a_res[j], m_res[0][j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, i % 4, $urandom_range(0, 4095), 1'b0, 0, 0);
            tests_run++;
            if ((a_dv !== m_valid[0]) || (a_res[i % 4] !== m_res[0][i % 4])) begin
                tests_failed++;
                $display("FAIL b2b sample %0d got v=%b r=%h exp v=%b r=%h",
                         i, a_dv, a_res[i % 4], m_valid[0], m_res[0][i % 4]);
            end
            if (a_dv === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 4) begin
            tests_failed++;
            $display("FAIL b2b_pulses got %0d exp 4", pulses);
        end
    endtask

    task automatic test_random();
        bit pa = 1'b0, pb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 4095),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 4095));
            tests_run++;
            if ((a_dv !== m_valid[0]) || (b_dv !== m_valid[1]) ||
                (a_ovf !== m_ovf[0]) || (b_ovf !== m_ovf[1])) begin
                tests_failed++;
                $display("FAIL rnd_flags cycle %0d got v=%b%b o=%b%b exp v=%b%b o=%b%b",
                         i, a_dv, b_dv, a_ovf, b_ovf, m_valid[0], m_valid[1], m_ovf[0], m_ovf[1]);
            end
            tests_run++;
            if ((pa && a_dv) || (pb && b_dv)) begin
                tests_failed++;
                $display("FAIL rnd_consecutive cycle %0d got a=%b b=%b exp no repeat", i, a_dv, b_dv);
            end
            pa = a_dv; pb = b_dv;
            for (int c = 0; c < 4; c++) begin
                tests_run++;
                if ((a_res[c] !== m_res[0][c]) || (b_res[c] !== m_res[1][c])) begin
                    tests_failed++;
                    $display("FAIL rnd_res%0d cycle %0d got a=%h b=%h exp a=%h b=%h",
                             c, i, a_res[c], b_res[c], m_res[0][c], m_res[1][c]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_full_scale_l5();
        test_overrun();
        test_reset_mid_frame();
        test_uneven();
        test_back_to_back();
        apply_reset(2);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ds_decim.md
# ds_decim

Four-channel decimating accumulator that sits directly upstream of the four-input sigma summing stage. It takes a time-multiplexed stream of ADC samples tagged by channel and sums 2^DS_LOG2 samples per channel. Once every channel has completed a block, it presents all four sums together as `ds_result0..3`, scaled to 16 bits. A one-cycle `ds_valid` pulse marks each coherent frame. A sticky flag records when a channel is overrun before the frame commits.

## Interface
- `DS_LOG2`, default 4: log2 of samples accumulated per channel per frame. Legal range 4..8.
- `ADC_W`, default 12: ADC sample width. Fixed at 12 for this release.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `adc_data` in 12: unsigned ADC sample.
- `adc_ch` in 2: channel tag of `adc_data`, 0..3.
- `adc_valid` in 1: sample qualifier. One sample per cycle at most; no backpressure.
- `ds_result0` out 16: committed decimated result, channel 0 (registered).
- `ds_result1` out 16: committed decimated result, channel 1.
- `ds_result2` out 16: committed decimated result, channel 2.
- `ds_result3` out 16: committed decimated result, channel 3.
- `ds_valid` out 1: one-cycle pulse; `ds_result0..3` updated on the same edge.
- `ds_ovf` out 1: sticky overrun flag. Cleared only by `rst`.

## Operation
- Per-channel state:
  - accumulator `acc[c]`, width 12+DS_LOG2;
  - sample counter `cnt[c]`, width DS_LOG2;
  - shadow register `shd[c]`, 16 bit;
  - `done[c]` flag.
- Accept: on an edge with `adc_valid=1`, channel c=`adc_ch`:
  - If `cnt[c]` < 2^DS_LOG2−1: `acc[c] += adc_data`, `cnt[c]++`.
  - If `cnt[c]` = 2^DS_LOG2−1, the block completes:
    - full sum S = `acc[c]` + `adc_data`;
    - `shd[c]` <= S[11+DS_LOG2 : DS_LOG2−4], i.e. the upper 16 bits, truncation without rounding;
    - `acc[c]` <= 0, `cnt[c]` <= 0, `done[c]` <= 1.
  - Accumulation restarts immediately; no samples are lost.
- Overrun: a block completes on channel c while `done[c]` is already 1:
  - `shd[c]` is overwritten with the newer value;
  - `ds_ovf` <= 1;
  - `done[c]` stays 1.
- Commit: a block completes and the resulting `done` vector (including this completion) is 4'b1111. On that same edge:
  - `ds_resultN` <= `shd[N]`, with the freshly computed value substituted for channel c;
  - `ds_valid` <= 1;
  - all `done` <= 0.
- Otherwise `ds_valid` <= 0. Outputs hold their last committed values between commits.
- Channel order is arbitrary: round-robin, bursty, or uneven are all legal.
- A frame commits only when all four channels have completed at least once since the last commit.
- `adc_valid=0`: no state change except `ds_valid` <= 0.
- Arithmetic is unsigned and cannot overflow, since the accumulator width is 12+DS_LOG2.
- At DS_LOG2=4 the result is the exact 16-bit sum.

## Timing
- Reset values after `rst` high at an edge:
  - `ds_result0..3` = 16'h0000, `ds_valid`=0, `ds_ovf`=0;
  - all `acc`, `cnt`, `shd`, `done` = 0.
- `rst` asserted mid-frame discards all partial accumulations and pending `done` flags. `rst` has priority over a coinciding sample.
- Latency: `ds_valid` and the new `ds_result` values are visible on the edge that captures the frame-completing sample (1 cycle after it is presented).
- Max throughput: one sample per clock. Back-to-back commits are legal only if every channel completes in between, so the minimum commit spacing is 4·2^DS_LOG2 samples.
- `ds_valid` is never high for two consecutive cycles.
- The downstream sigma stage registers on every clock. It sees the new results one cycle after `ds_valid`. At most 18 bits are needed there (4×16'hFFF0 = 18'h3FFC0).

## Test plan
- Reset: apply `rst` for 2 cycles with `adc_valid` toggling -> all outputs 0, no `ds_valid`.
- DS_LOG2=4, round-robin channels 0..3, constant 12'hABC, 64 samples -> single `ds_valid` pulse on the edge after the 64th sample; all results 16'hABC0; `ds_ovf`=0.
- DS_LOG2=5, all samples 12'hFFF, 128 round-robin samples -> results 16'hFFF0 (sum 17'h1FFE0 truncated); exactly one pulse.
- DS_LOG2=4, ramp 0..15 on channel 2 only, 32 samples -> no `ds_valid`, `ds_ovf`=1. Then 16 samples of 12'h001 on each of channels 0, 1, 3 -> commit with ds_result2=16'h0078 (sum of the second ramp) and ds_result0/1/3=16'h0010.
- Reset mid-frame: 8 samples per channel of 12'h100, then `rst`, then a full 64-sample frame of 12'h010 -> ds_result*=16'h0100, with no residue from before the reset.
- Uneven order: channel 3 first (16 samples), then 0, 1, 2 interleaved with `adc_valid` gaps -> commit exactly on the edge after the 16th sample of the last channel to complete.
